// File: rtl/xgriscv_runctl_pkg.sv
// Shared definitions for the xgriscv run controller: state encodings and defaults.
// Benches import this to decode state_o.
package xgriscv_runctl_pkg;

    typedef enum logic [1:0] {
        RC_IDLE   = 2'd0,
        RC_RUN    = 2'd1,
        RC_STEP   = 2'd2,
        RC_HALTED = 2'd3
    } rc_state_e;

    localparam logic [31:0] RC_DEFAULT_HALT_PC = 32'h00000CCC;
    localparam logic [31:0] RC_DEFAULT_TIMEOUT = 32'd100000;

    // States in which the watchdog and cycle counter advance.
    function automatic logic rc_active(rc_state_e s);
        return (s == RC_RUN) || (s == RC_STEP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/xgriscv_runctl.sv
// Run controller for xgriscv_sc: gates the core clock-enable through idle/run/step/halted
// and stops it on the halt PC or when the cycle watchdog expires.
module xgriscv_runctl
    import xgriscv_runctl_pkg::*;
#(
    parameter logic [31:0] HALT_PC = RC_DEFAULT_HALT_PC,
    parameter logic [31:0] TIMEOUT = RC_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run_i,
    input  logic        step_i,
    input  logic        pause_i,
    input  logic        clr_i,
    input  logic [31:0] pc_i,
    output logic        cpu_en_o,
    output logic [1:0]  state_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o,
    output logic        done_o,
    output logic        timeout_o
);

    rc_state_e state_q;
    logic      done_q;
    logic      timeout_q;
    logic      active;
    logic      at_halt;
    logic      wdog_hit;
    logic      cnt_clr;

    assign active   = rc_active(state_q);
    assign at_halt  = (pc_i == HALT_PC);
    // The halt-PC instruction itself must never execute, hence the combinational gate.
    assign cpu_en_o = active && !at_halt;

    // Widened compare so TIMEOUT = 32'hFFFFFFFF cannot wrap the +1.
    assign wdog_hit = (({1'b0, cycle_cnt_o} + 33'd1) == {1'b0, TIMEOUT});
    assign cnt_clr  = clr_i && ((state_q == RC_IDLE) || (state_q == RC_HALTED));

    assign state_o   = state_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

    sat_counter #(
        .WIDTH(32)
    ) u_cycle_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (cnt_clr),
        .inc (active),
        .q   (cycle_cnt_o)
    );

    sat_counter #(
        .WIDTH(32)
    ) u_instr_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (cnt_clr),
        .inc (cpu_en_o),
        .q   (instr_cnt_o)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= RC_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                RC_IDLE: begin
                    if (run_i) begin
                        state_q <= RC_RUN;
                    end else if (step_i) begin
                        state_q <= RC_STEP;
                    end
                end
                RC_RUN, RC_STEP: begin
                    // Halt PC outranks the watchdog so only done_o is raised on a tie.
                    if (at_halt) begin
                        state_q <= RC_HALTED;
                        done_q  <= 1'b1;
                    end else if (wdog_hit) begin
                        state_q   <= RC_HALTED;
                        timeout_q <= 1'b1;
                    end else if ((state_q == RC_STEP) || pause_i) begin
                        state_q <= RC_IDLE;
                    end
                end
                RC_HALTED: begin
                    if (clr_i) begin
                        state_q   <= RC_IDLE;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_runctl.sv
// Scoreboard bench for xgriscv_runctl: two instances (default and short watchdog) driven in
// lockstep, checked against a rule-level model; plus a narrow sat_counter saturation check.
module tb_xgriscv_runctl;
    import xgriscv_runctl_pkg::*;

    localparam logic [31:0] HPC   = 32'h00000CCC;
    localparam longint      TO_A  = 100000;
    localparam longint      TO_B  = 16;
    localparam longint      SATMX = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        int     mode;  // 0 idle, 1 run, 2 step, 3 halted
        longint cyc;
        longint ins;
        bit     done;
        bit     tmo;
    } mdl_t;

    typedef struct {
        bit   rst;
        bit   en_a;
        bit   en_b;
        mdl_t a;
        mdl_t b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        run_i = 1'b0, step_i = 1'b0, pause_i = 1'b0, clr_i = 1'b0;
    logic [31:0] pc_a = '0, pc_b = '0;
    logic        en_a, en_b, done_a, done_b, tmo_a, tmo_b;
    logic [1:0]  state_a, state_b;
    logic [31:0] cyc_a, cyc_b, ins_a, ins_b;
    logic        sc_rst = 1'b1, sc_clr = 1'b0, sc_inc = 1'b0;
    logic [3:0]  sc_q;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_issued = 0;
    int   n_checked = 0;
    exp_t sb[$];
    mdl_t ma, mb;
    logic [31:0] core_a = '0, core_b = '0;
    bit   pc_rand = 1'b0;

    always #5 clk = ~clk;

    xgriscv_runctl u_dut_a (
        .clk(clk), .rstn(rstn), .run_i(run_i), .step_i(step_i), .pause_i(pause_i),
        .clr_i(clr_i), .pc_i(pc_a), .cpu_en_o(en_a), .state_o(state_a),
        .cycle_cnt_o(cyc_a), .instr_cnt_o(ins_a), .done_o(done_a), .timeout_o(tmo_a)
    );

    xgriscv_runctl #(
        .HALT_PC(32'h00000CCC),
        .TIMEOUT(32'd16)
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .run_i(run_i), .step_i(step_i), .pause_i(pause_i),
        .clr_i(clr_i), .pc_i(pc_b), .cpu_en_o(en_b), .state_o(state_b),
        .cycle_cnt_o(cyc_b), .instr_cnt_o(ins_b), .done_o(done_b), .timeout_o(tmo_b)
    );

    sat_counter #(
        .WIDTH(4)
    ) u_sat (
        .clk(clk), .rstn(sc_rst), .clr(sc_clr), .inc(sc_inc), .q(sc_q)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint x);
        return (x > SATMX) ? SATMX : x;
    endfunction

    function automatic bit en_of(input mdl_t m, input bit rst, input logic [31:0] pc);
        return !rst && (m.mode == 1 || m.mode == 2) && (pc != HPC);
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input bit rst, input bit run,
                                      input bit step, input bit pause, input bit clr,
                                      input logic [31:0] pc, input longint lim);
        mdl_t n;
        n = m;
        if (rst) begin
            n.mode = 0; n.cyc = 0; n.ins = 0; n.done = 0; n.tmo = 0;
            return n;
        end
        case (m.mode)
            0: begin
                if (clr) begin n.cyc = 0; n.ins = 0; end
                if (run) n.mode = 1;
                else if (step) n.mode = 2;
            end
            1, 2: begin
                n.cyc = sat(m.cyc + 1);
                if (pc != HPC) n.ins = sat(m.ins + 1);
                if (pc == HPC) begin n.mode = 3; n.done = 1; end
                else if (m.cyc + 1 == lim) begin n.mode = 3; n.tmo = 1; end
                else if (m.mode == 2 || pause) n.mode = 0;
            end
            default: begin
                if (clr) begin
                    n.mode = 0; n.cyc = 0; n.ins = 0; n.done = 0; n.tmo = 0;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 5) == 0) ? HPC : ($urandom & 32'hFFFF_FFFC);
    endfunction

    // One clock cycle of stimulus, entered and left at posedge+2.
    task automatic cycle(input bit rst, input bit run, input bit step, input bit pause,
                         input bit clr);
        exp_t e;
        rstn = rst; run_i = run; step_i = step; pause_i = pause; clr_i = clr;
        if (pc_rand) begin
            pc_a = rand_pc();
            pc_b = rand_pc();
        end else begin
            pc_a = core_a;
            pc_b = core_b;
        end
        e.rst  = rst;
        e.en_a = en_of(ma, rst, pc_a);
        e.en_b = en_of(mb, rst, pc_b);
        ma = mdl_next(ma, rst, run, step, pause, clr, pc_a, TO_A);
        mb = mdl_next(mb, rst, run, step, pause, clr, pc_b, TO_B);
        e.a = ma;
        e.b = mb;
        if (e.en_a) core_a = core_a + 32'd4;
        if (e.en_b) core_b = core_b + 32'd4;
        sb.push_back(e);
        n_issued++;
        @(posedge clk);
        #2;
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        chk({tag, "_state_a"}, state_a, e.a.mode);
        chk({tag, "_cyc_a"}, cyc_a, e.a.cyc);
        chk({tag, "_ins_a"}, ins_a, e.a.ins);
        chk({tag, "_done_a"}, done_a, e.a.done);
        chk({tag, "_tmo_a"}, tmo_a, e.a.tmo);
        chk({tag, "_state_b"}, state_b, e.b.mode);
        chk({tag, "_cyc_b"}, cyc_b, e.b.cyc);
        chk({tag, "_ins_b"}, ins_b, e.b.ins);
        chk({tag, "_done_b"}, done_b, e.b.done);
        chk({tag, "_tmo_b"}, tmo_b, e.b.tmo);
    endtask

    // Monitor: enable mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("en_a", en_a, e.en_a);
                chk("en_b", en_b, e.en_b);
                if (e.rst) check_regs("async_rst", e);
                @(posedge clk);
                #1;
                check_regs("post_edge", e);
                n_checked++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checked %0d of %0d",
                 n_checked, n_issued);
        $fatal(1);
    end

    initial begin
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        @(posedge clk);
        #2;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Free run to the halt PC.
        core_a = '0; core_b = '0;
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 900 && ma.mode != 3; i++) cycle(0, 0, 0, 0, 0);
        chk("halt_state", state_a, 3);
        chk("halt_done", done_a, 1);
        chk("halt_tmo", timeout_clean(tmo_a), 0);
        chk("halt_instr", ins_a, 819);
        chk("halt_cycle", cyc_a, 820);

        // Halted ignores run/step/pause; clr releases.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("halted_hold_state", state_a, 3);
        chk("halted_hold_cycle", cyc_a, 820);
        cycle(0, 0, 0, 0, 1);
        chk("clr_state", state_a, 0);
        chk("clr_done", done_a, 0);
        chk("clr_cycle", cyc_a, 0);
        chk("clr_tmo_b", tmo_b, 0);

        // Three spaced single steps.
        core_a = '0; core_b = '0;
        for (int s = 0; s < 3; s++) begin
            cycle(0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 0);
            chk("step_back_idle", state_a, 0);
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        chk("step_instr", ins_a, 3);
        chk("step_cycle", cyc_a, 3);

        // Watchdog on the short-timeout instance.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 40 && mb.mode != 3; i++) cycle(0, 0, 0, 0, 0);
        chk("wdog_state", state_b, 3);
        chk("wdog_tmo", tmo_b, 1);
        chk("wdog_done", done_b, 0);
        chk("wdog_cycle", cyc_b, 16);

        // Pause keeps the count; a later run resumes from it.
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("pause_pre_clr", cyc_a, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("pause_state", state_a, 0);
        chk("pause_cycle", cyc_a, 5);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("resume_cycle", cyc_a, 7);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("idle_clr_cycle", cyc_a, 0);
        chk("idle_clr_instr", ins_a, 0);

        // Asynchronous reset mid-run, then run+step together.
        cycle(0, 1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("midrun_rst_cycle", cyc_a, 0);
        cycle(0, 1, 1, 0, 0);
        chk("run_wins", state_a, 1);
        cycle(0, 0, 0, 1, 0);

        // Random traffic.
        pc_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
        end
        cycle(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && n_checked != n_issued; i++) @(posedge clk);
        #2;
        chk("drain", n_checked, n_issued);

        // Saturation on a narrow counter.
        sc_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            sc_inc = 1'b1;
            @(posedge clk);
            #2;
            chk("sat_q", sc_q, (k < 15) ? k : 15);
        end
        sc_inc = 1'b0;
        sc_clr = 1'b1;
        @(posedge clk);
        #2;
        chk("sat_clr", sc_q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic logic timeout_clean(input logic t);
        return t;
    endfunction

endmodule
